vadd_launcher: RTL and testbench

VADD_LAUNCHER -- requirements
Module: vadd_launcher

---
 rtl/vadd_launcher.sv | 230 +++++++++++++++++++++++
 tb/tb_vadd_launcher.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_launcher.sv
// vadd_launcher: launches a vector-add kernel through its AXI4-Lite control
// port. It writes LEN and the A/B/C buffer addresses, then writes ap_start.
// It polls CTRL until ap_done is set, and finishes with a done pulse or an
// err pulse.
// Optional feature: define VADD_LAUNCH_TIMEOUT_EN to give up polling after
// TIMEOUT_POLLS status reads (err_code 3).
module vadd_launcher #(
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32,
  parameter int POLL_GAP                   = 16,
  parameter int TIMEOUT_POLLS              = 1024
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [63:0]                             cmd_a_addr,
  input  logic [63:0]                             cmd_b_addr,
  input  logic [63:0]                             cmd_c_addr,
  input  logic [31:0]                             cmd_len,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err,
  output logic [1:0]                              err_code,
  output logic                                    m_axil_awvalid,
  input  logic                                    m_axil_awready,
  output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                                    m_axil_wvalid,
  input  logic                                    m_axil_wready,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic                                    m_axil_bvalid,
  output logic                                    m_axil_bready,
  input  logic [1:0]                              m_axil_bresp,
  output logic                                    m_axil_arvalid,
  input  logic                                    m_axil_arready,
  output logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   m_axil_araddr,
  input  logic                                    m_axil_rvalid,
  output logic                                    m_axil_rready,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                              m_axil_rresp
);

  localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;
  localparam int DW = C_S_AXI_CONTROL_DATA_WIDTH;
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP, GAP, FIN} state_t;

  state_t      state, state_n;
  logic [2:0]  wr_idx, idx_n;
  logic        aw_ok, aw_ok_n, w_ok, w_ok_n;
  logic        aw_hit, w_hit, enter_rd;
  logic [7:0]  gap_cnt, gap_n;
  logic [1:0]  code_q, code_n;
  logic [31:0] len_q;
  logic [63:0] a_q, b_q, c_q;
  logic [7:0]  reg_off;
  logic [31:0] reg_data;
  logic        unused_bits;

`ifdef VADD_LAUNCH_TIMEOUT_EN
  localparam logic [10:0] TO_LIM = 11'(TIMEOUT_POLLS);
  logic [10:0] poll_cnt, poll_n;
  assign unused_bits = ^{m_axil_rdata[DW-1:2], m_axil_rdata[0]};
`else
  assign unused_bits = ^{m_axil_rdata[DW-1:2], m_axil_rdata[0], TIMEOUT_POLLS != 0};
`endif

  // State register, write/poll bookkeeping and command capture on accept
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      wr_idx  <= '0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      gap_cnt <= '0;
      code_q  <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
`ifdef VADD_LAUNCH_TIMEOUT_EN
      poll_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      wr_idx  <= idx_n;
      aw_ok   <= aw_ok_n;
      w_ok    <= w_ok_n;
      gap_cnt <= gap_n;
      code_q  <= code_n;
`ifdef VADD_LAUNCH_TIMEOUT_EN
      poll_cnt <= poll_n;
`endif
      if (state == IDLE && cmd_valid) begin
        len_q <= cmd_len;
        a_q   <= cmd_a_addr;
        b_q   <= cmd_b_addr;
        c_q   <= cmd_c_addr;
      end
    end
  end

  // Next-state logic; every path that leads to a status read goes through enter_rd
  always_comb begin
    state_n  = state;
    idx_n    = wr_idx;
    aw_ok_n  = aw_ok;
    w_ok_n   = w_ok;
    gap_n    = gap_cnt;
    code_n   = code_q;
    aw_hit   = 1'b0;
    w_hit    = 1'b0;
    enter_rd = 1'b0;
`ifdef VADD_LAUNCH_TIMEOUT_EN
    poll_n   = poll_cnt;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n = WR;
          idx_n   = '0;
          aw_ok_n = 1'b0;
          w_ok_n  = 1'b0;
          code_n  = 2'd0;
`ifdef VADD_LAUNCH_TIMEOUT_EN
          poll_n  = '0;
`endif
        end
      end
      WR: begin
        aw_hit  = aw_ok | m_axil_awready;
        w_hit   = w_ok | m_axil_wready;
        aw_ok_n = aw_hit;
        w_ok_n  = w_hit;
        if (aw_hit && w_hit) state_n = WR_RESP;
      end
      WR_RESP: begin
        if (m_axil_bvalid) begin
          if (m_axil_bresp != 2'b00) begin
            state_n = FIN;
            code_n  = 2'd1;
          end else begin
            aw_ok_n = 1'b0;
            w_ok_n  = 1'b0;
            if (wr_idx == 3'd7) begin
              enter_rd = 1'b1;
            end else begin
              idx_n   = wr_idx + 3'd1;
              state_n = WR;
            end
          end
        end
      end
      RD: begin
        if (m_axil_arready) state_n = RD_RESP;
      end
      RD_RESP: begin
        if (m_axil_rvalid) begin
          if (m_axil_rresp != 2'b00) begin
            state_n = FIN;
            code_n  = 2'd2;
          end else if (m_axil_rdata[1]) begin
            state_n = FIN;
            code_n  = 2'd0;
          end else begin
            state_n = GAP;
            gap_n   = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) enter_rd = 1'b1;
        else gap_n = gap_cnt + 8'd1;
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (enter_rd) begin
`ifdef VADD_LAUNCH_TIMEOUT_EN
      if (poll_cnt == TO_LIM) begin
        state_n = FIN;
        code_n  = 2'd3;
      end else begin
        state_n = RD;
        poll_n  = poll_cnt + 11'd1;
      end
`else
      state_n = RD;
`endif
    end
  end

  // Register offset and payload for the current write, from the captured command
  always_comb begin
    reg_off  = 8'h00;
    reg_data = 32'h0000_0001;
    case (wr_idx)
      3'd0: begin reg_off = 8'h10; reg_data = len_q;        end
      3'd1: begin reg_off = 8'h18; reg_data = a_q[31:0];    end
      3'd2: begin reg_off = 8'h1C; reg_data = a_q[63:32];   end
      3'd3: begin reg_off = 8'h24; reg_data = b_q[31:0];    end
      3'd4: begin reg_off = 8'h28; reg_data = b_q[63:32];   end
      3'd5: begin reg_off = 8'h30; reg_data = c_q[31:0];    end
      3'd6: begin reg_off = 8'h34; reg_data = c_q[63:32];   end
      default: begin reg_off = 8'h00; reg_data = 32'h0000_0001; end
    endcase
  end

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == FIN) && (code_q == 2'd0);
  assign err            = (state == FIN) && (code_q != 2'd0);
  assign err_code       = (state == FIN) ? code_q : 2'd0;
  assign m_axil_awvalid = (state == WR) && !aw_ok;
  assign m_axil_wvalid  = (state == WR) && !w_ok;
  assign m_axil_awaddr  = AW'(reg_off);
  assign m_axil_wdata   = DW'(reg_data);
  assign m_axil_wstrb   = '1;
  assign m_axil_bready  = (state == WR_RESP);
  assign m_axil_arvalid = (state == RD);
  assign m_axil_araddr  = '0;
  assign m_axil_rready  = (state == RD_RESP);

endmodule

// File: tb/tb_vadd_launcher.sv
// Testbench for vadd_launcher: a configurable AXI4-Lite slave plus a
// reference model of the launch outcome. The model predicts the write list,
// the number of status reads and the completion code.
module tb_vadd_launcher;

  localparam int TB_GAP = 16;
  localparam int TB_TO  = 4;
`ifdef VADD_LAUNCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        ap_clk, ap_rst;
  logic        cmd_valid, cmd_ready;
  logic [63:0] cmd_a_addr, cmd_b_addr, cmd_c_addr;
  logic [31:0] cmd_len;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [11:0] m_axil_awaddr, m_axil_araddr;
  logic [31:0] m_axil_wdata, m_axil_rdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;
  logic [1:0]  m_axil_bresp, m_axil_rresp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int gen   = 0;
  int k_aw_d, k_w_d, k_b_d, k_ar_d, k_r_d, k_bad_w, k_rerr, k_done_after;

  logic [11:0] aw_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [11:0] ar_q[$];
  int          rt_q[$];

  vadd_launcher #(
    .C_S_AXI_CONTROL_ADDR_WIDTH(12),
    .C_S_AXI_CONTROL_DATA_WIDTH(32),
    .POLL_GAP(TB_GAP),
    .TIMEOUT_POLLS(TB_TO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
    .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready), .m_axil_awaddr(m_axil_awaddr),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_wdata(m_axil_wdata),
    .m_axil_wstrb(m_axil_wstrb),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready), .m_axil_araddr(m_axil_araddr),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready), .m_axil_rdata(m_axil_rdata),
    .m_axil_rresp(m_axil_rresp)
  );

  // Free-running clock
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // AXI4-Lite slave: readies and responses change on the falling edge, and
  // a handshake is logged when valid and ready are both high going into the
  // next rising edge
  initial begin
    int my_gen, aw_c, w_c, b_c, ar_c, r_c, b_n, r_n;
    bit b_fire, r_fire;
    my_gen = -1;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; b_n = 0; r_n = 0;
    b_fire = 0; r_fire = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
    m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (my_gen != gen) begin
        my_gen = gen;
        aw_q.delete(); wd_q.delete(); ws_q.delete(); ar_q.delete(); rt_q.delete();
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; b_n = 0; r_n = 0;
        b_fire = 0; r_fire = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
        m_axil_arready = 0; m_axil_rvalid = 0;
      end
      if (b_fire) begin m_axil_bvalid = 0; b_fire = 0; b_c = 0; end
      if (!m_axil_bvalid && b_n < aw_q.size() && b_n < wd_q.size()) begin
        if (b_c >= k_b_d) begin
          m_axil_bvalid = 1;
          m_axil_bresp  = (b_n == k_bad_w) ? 2'b10 : 2'b00;
        end else b_c++;
      end
      if (m_axil_bvalid && m_axil_bready) begin b_fire = 1; b_n++; end
      if (m_axil_awvalid) begin m_axil_awready = (aw_c >= k_aw_d); aw_c++; end
      else begin m_axil_awready = 0; aw_c = 0; end
      if (m_axil_awvalid && m_axil_awready) begin aw_q.push_back(m_axil_awaddr); aw_c = 0; end
      if (m_axil_wvalid) begin m_axil_wready = (w_c >= k_w_d); w_c++; end
      else begin m_axil_wready = 0; w_c = 0; end
      if (m_axil_wvalid && m_axil_wready) begin
        wd_q.push_back(m_axil_wdata); ws_q.push_back(m_axil_wstrb); w_c = 0;
      end
      if (r_fire) begin m_axil_rvalid = 0; r_fire = 0; r_c = 0; end
      if (!m_axil_rvalid && r_n < ar_q.size()) begin
        if (r_c >= k_r_d) begin
          m_axil_rvalid   = 1;
          m_axil_rdata    = $urandom;
          m_axil_rdata[1] = (r_n >= k_done_after);
          m_axil_rresp    = (r_n == k_rerr) ? 2'b10 : 2'b00;
        end else r_c++;
      end
      if (m_axil_rvalid && m_axil_rready) begin r_fire = 1; r_n++; end
      if (m_axil_arvalid) begin m_axil_arready = (ar_c >= k_ar_d); ar_c++; end
      else begin m_axil_arready = 0; ar_c = 0; end
      if (m_axil_arvalid && m_axil_arready) begin
        ar_q.push_back(m_axil_araddr); rt_q.push_back(cyc); ar_c = 0;
      end
    end
  end

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of a launch from the slave's behaviour: writes issued, status reads, code
  function automatic void model(input int bad_w, input int rerr, input int done_after,
                                output int nw, output int nr, output int code);
    nw = 8; nr = 0; code = 0;
    if (bad_w >= 0) begin
      nw = bad_w + 1; code = 1;
      return;
    end
    while (1) begin
      if (TO_EN && nr == TB_TO) begin code = 3; break; end
      nr++;
      if (nr - 1 == rerr) begin code = 2; break; end
      if (nr - 1 >= done_after) begin code = 0; break; end
    end
  endfunction

  // One complete launch: configure the slave, issue the command, wait for the
  // outcome, then compare everything against the model
  task automatic applyStimulus(input string tag, input logic [31:0] len,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                               input int aw_d, input int w_d, input int b_d, input int ar_d,
                               input int r_d, input int bad_w, input int rerr,
                               input int done_after, input bit hold,
                               output int lat, output int min_gap);
    int nw, nr, code, waited, c0, aw_before;
    logic [11:0] ea[8];
    logic [31:0] ed[8];
    logic got_done, got_err;
    logic [1:0] got_code;
    k_aw_d = aw_d; k_w_d = w_d; k_b_d = b_d; k_ar_d = ar_d; k_r_d = r_d;
    k_bad_w = bad_w; k_rerr = rerr; k_done_after = done_after;
    gen++;
    @(negedge ap_clk); #1;
    checkOutput({tag, ".ready_before"}, cmd_ready, 1);
    cmd_len = len; cmd_a_addr = a; cmd_b_addr = b; cmd_c_addr = c; cmd_valid = 1;
    c0 = cyc;
    @(negedge ap_clk); #1;
    checkOutput({tag, ".busy_after_accept"}, busy, 1);
    checkOutput({tag, ".ready_while_busy"}, cmd_ready, 0);
    if (hold) begin
      cmd_a_addr = ~a; cmd_len = len ^ 32'h0000_FFFF;
    end else cmd_valid = 0;
    waited = 0;
    while (!(done || err) && waited < 3000) begin
      @(negedge ap_clk); #1;
      waited++;
    end
    checkOutput({tag, ".finished"}, done || err, 1);
    got_done = done; got_err = err; got_code = err_code;
    lat = cyc - c0;
    cmd_valid = 0;
    model(bad_w, rerr, done_after, nw, nr, code);
    ea = '{12'h010, 12'h018, 12'h01C, 12'h024, 12'h028, 12'h030, 12'h034, 12'h000};
    ed = '{len, a[31:0], a[63:32], b[31:0], b[63:32], c[31:0], c[63:32], 32'h1};
    checkOutput({tag, ".done"}, got_done, code == 0);
    checkOutput({tag, ".err"}, got_err, code != 0);
    checkOutput({tag, ".err_code"}, got_code, code);
    checkOutput({tag, ".aw_count"}, aw_q.size(), nw);
    checkOutput({tag, ".w_count"}, wd_q.size(), nw);
    checkOutput({tag, ".rd_count"}, ar_q.size(), nr);
    for (int i = 0; i < nw && i < aw_q.size() && i < wd_q.size(); i++) begin
      checkOutput($sformatf("%s.awaddr%0d", tag, i), aw_q[i], ea[i]);
      checkOutput($sformatf("%s.wdata%0d", tag, i), wd_q[i], ed[i]);
      checkOutput($sformatf("%s.wstrb%0d", tag, i), ws_q[i], 4'hF);
    end
    for (int i = 0; i < ar_q.size(); i++)
      checkOutput($sformatf("%s.araddr%0d", tag, i), ar_q[i], 0);
    min_gap = 100000;
    for (int i = 1; i < rt_q.size(); i++)
      if (rt_q[i] - rt_q[i-1] < min_gap) min_gap = rt_q[i] - rt_q[i-1];
    @(negedge ap_clk); #1;
    checkOutput({tag, ".done_pulse_end"}, done, 0);
    checkOutput({tag, ".err_pulse_end"}, err, 0);
    checkOutput({tag, ".err_code_idle"}, err_code, 0);
    checkOutput({tag, ".busy_fell"}, busy, 0);
    checkOutput({tag, ".ready_after"}, cmd_ready, 1);
    aw_before = aw_q.size();
    repeat (3) @(negedge ap_clk);
    #1;
    checkOutput({tag, ".no_extra_launch"}, aw_q.size(), aw_before);
  endtask

  // Directed scenarios followed by randomized launches
  initial begin
    int lat, mg, nw, nr, code;
    bit saw;
    logic [63:0] ra, rb, rc;
    ap_rst = 1; cmd_valid = 0; cmd_len = 0; cmd_a_addr = 0; cmd_b_addr = 0; cmd_c_addr = 0;
    k_aw_d = 0; k_w_d = 0; k_b_d = 0; k_ar_d = 0; k_r_d = 0;
    k_bad_w = -1; k_rerr = -1; k_done_after = 0;
    repeat (3) @(negedge ap_clk);
    #1 ap_rst = 0;
    @(negedge ap_clk); #1;
    checkOutput("rst.cmd_ready", cmd_ready, 1);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    checkOutput("rst.err", err, 0);
    checkOutput("rst.err_code", err_code, 0);
    checkOutput("rst.valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    checkOutput("rst.readies", {m_axil_bready, m_axil_rready}, 0);

    $display("[TB] zero-wait launch");
    applyStimulus("basic", 32'd256, 64'h1000, 64'h2000, 64'h3000,
                  0, 0, 0, 0, 0, -1, -1, 0, 0, lat, mg);
    checkOutput("basic.latency_le_19", lat <= 19, 1);

    $display("[TB] W lags AW, four not-done polls");
    applyStimulus("poll", 32'h55, 64'h1_2345_6789, 64'hAB_0000_0010, 64'hFFFF_FFFF_0000_0004,
                  0, 3, 0, 0, 0, -1, -1, 4, 0, lat, mg);
    checkOutput("poll.gap_ok", mg >= TB_GAP + 1, 1);

    $display("[TB] BRESP error on third write");
    applyStimulus("bresp", 32'd9, 64'hA0, 64'hB0, 64'hC0,
                  1, 0, 1, 0, 0, 2, -1, 0, 0, lat, mg);

    $display("[TB] RRESP error on second poll");
    applyStimulus("rresp", 32'd7, 64'h10, 64'h20, 64'h30,
                  0, 0, 0, 1, 1, -1, 1, 3, 0, lat, mg);

    $display("[TB] slow ap_done, timeout when enabled");
    applyStimulus("slow", 32'd1, 64'h11, 64'h22, 64'h33,
                  0, 0, 0, 0, 0, -1, -1, 6, 0, lat, mg);
    model(-1, -1, 6, nw, nr, code);
    checkOutput("slow.model_reads", ar_q.size(), nr);

    $display("[TB] cmd_valid held high through a launch");
    applyStimulus("hold", 32'hDEAD, 64'h4444_0000, 64'h5555_0000, 64'h6666_0000,
                  2, 1, 0, 0, 0, -1, -1, 1, 1, lat, mg);

    $display("[TB] reset while AW is stalled");
    k_aw_d = 100000; k_w_d = 0; k_b_d = 0; k_bad_w = -1; k_rerr = -1; k_done_after = 0;
    gen++;
    @(negedge ap_clk); #1;
    cmd_len = 32'd3; cmd_a_addr = 64'h1; cmd_b_addr = 64'h2; cmd_c_addr = 64'h3; cmd_valid = 1;
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge ap_clk); #1;
      cmd_valid = 0;
      if (m_axil_awvalid) saw = 1;
    end
    checkOutput("rstmid.saw_awvalid", saw, 1);
    ap_rst = 1;
    @(negedge ap_clk); #1;
    ap_rst = 0;
    checkOutput("rstmid.valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 0);
    checkOutput("rstmid.busy", busy, 0);
    checkOutput("rstmid.pulses", {done, err, err_code}, 0);
    checkOutput("rstmid.cmd_ready", cmd_ready, 1);
    checkOutput("rstmid.no_aw", aw_q.size(), 0);
    applyStimulus("after_rst", 32'd64, 64'h7000, 64'h8000, 64'h9000,
                  0, 0, 0, 0, 0, -1, -1, 0, 0, lat, mg);

    $display("[TB] randomized launches");
    for (int it = 0; it < 8; it++) begin
      int bw, re;
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = {$urandom, $urandom};
      bw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      re = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
      applyStimulus($sformatf("rnd%0d", it), $urandom, ra, rb, rc,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), bw, re,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, mg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
